// File: rtl/data_sram_slave.sv
// ---------------------------------------------------------------------------
// data_sram_slave
//   Data-side memory responder for the pipelined MIPS core. Word-organised
//   RAM behind a req/addr_ok/data_ok handshake. The response latency is set by
//   a parameter so the core's stall logic sees real wait states. Loads always
//   return the full aligned word; the core does lane extract/extend.
//
// Parameters
//   ADDR_W   word-address bits, depth = 2**ADDR_W words (upper byte-address
//            bits are ignored, so addresses wrap)
//   LATENCY  cycles from accept edge to the data_ok cycle, 1..15
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   req      access request, fields held stable until accepted
//   wr       1 = store, 0 = load
//   size     00 byte, 01 half, 10/11 word
//   wstrb    byte-lane write enables
//   addr     byte address
//   wdata    lane-aligned store data
//   addr_ok  request accepted on an edge where req & addr_ok
//   data_ok  one-cycle response pulse
//   rdata    aligned load word with data_ok, 0 otherwise and for stores
//   err      misaligned-access flag with data_ok
// ---------------------------------------------------------------------------
module data_sram_slave #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request captured at accept; everything the BUSY/RESP phases still need.
  typedef struct packed {
    logic              wr;
    logic              misAl;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       wdata;
  } pendReq_t;

  // With a one-cycle latency the access goes straight to the response state.
  localparam state_t START_STATE = (LATENCY > 1) ? BUSY : RESP;

  state_t            state;
  state_t            nextState;
  logic [CNT_W-1:0]  cnt;
  pendReq_t          pend;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              inMisal;
  logic [ADDR_W-1:0] inIdx;
  logic              commitWr;
  logic [ADDR_W-1:0] rdIdx;
  logic              rdLoad;
  logic              rdErr;
  logic [31:0]       rdWord;

  // Byte-address bits above the RAM depth are ignored.
  logic unusedAddrHi;
  assign unusedAddrHi = ^addr[31:ADDR_W+2];

  // Next-state, alignment check, read-port selection and store/load merge.
  always_comb begin
    accept    = req && addr_ok;
    inIdx     = addr[ADDR_W+1:2];
    inMisal   = 1'b0;
    nextState = state;
    commitWr  = 1'b0;
    rdIdx     = inIdx;
    rdLoad    = 1'b0;
    rdErr     = 1'b0;
    rdWord    = '0;

    if (size == 2'b01) begin
      inMisal = addr[0];
    end else if (size[1]) begin
      inMisal = (addr[1:0] != 2'b00);
    end

    case (state)
      IDLE:    if (accept) nextState = START_STATE;
      BUSY:    if (cnt == CNT_W'(1)) nextState = RESP;
      RESP:    nextState = accept ? START_STATE : IDLE;
      default: nextState = IDLE;
    endcase

    // The pending store lands on the edge that leaves RESP.
    commitWr = (state == RESP) && pend.wr && !pend.misAl;

    // Read source: the held request when finishing a wait, otherwise the
    // request being accepted right now (one-cycle latency).
    if (state == BUSY) begin
      rdIdx  = pend.wordIdx;
      rdLoad = !pend.wr && !pend.misAl;
      rdErr  = pend.misAl;
    end else begin
      rdIdx  = inIdx;
      rdLoad = !wr && !inMisal;
      rdErr  = inMisal;
    end

    rdWord = mem[rdIdx];
    // A store committing on the same edge to the same word must be visible.
    if (commitWr && (pend.wordIdx == rdIdx)) begin
      for (int i = 0; i < 4; i++) begin
        if (pend.wstrb[i]) rdWord[8*i +: 8] = pend.wdata[8*i +: 8];
      end
    end
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      addr_ok <= 1'b1;
      data_ok <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= nextState;
      addr_ok <= (nextState != BUSY);
      data_ok <= (nextState == RESP);

      if (accept) begin
        pend.wr      <= wr;
        pend.misAl   <= inMisal;
        pend.wstrb   <= wstrb;
        pend.wordIdx <= inIdx;
        pend.wdata   <= wdata;
        cnt          <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (nextState == RESP) begin
        rdata <= rdLoad ? rdWord : 32'h0;
        err   <= rdErr;
      end else begin
        rdata <= 32'h0;
        err   <= 1'b0;
      end
    end
  end

  // RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (commitWr) begin
      for (int i = 0; i < 4; i++) begin
        if (pend.wstrb[i]) mem[pend.wordIdx][8*i +: 8] <= pend.wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_data_sram_slave
//   Four instances with LATENCY 1..4 run the same directed sequence plus a
//   random sweep. Each driver pushes the expected response when a request is
//   accepted; a per-instance monitor pops and compares on every data_ok,
//   including the cycle the response arrives on.
// ---------------------------------------------------------------------------
module tb_data_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int nCompared = 0;
  int nMismatch = 0;
  int nDone     = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int unsigned LAT = g + 1;

    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    exp_t        q[$];
    logic [31:0] model [1024];

    data_sram_slave #(.ADDR_W(10), .LATENCY(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata),
      .err     (err)
    );

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
      exp_t e;
      if (data_ok) begin
        nCompared++;
        if (q.size() == 0) begin
          nMismatch++;
          $display("FAIL lat%0d unexpected data_ok: rdata=%h err=%b cyc=%0d", LAT, rdata, err, cyc);
        end else begin
          e = q.pop_front();
          if (rdata !== e.rdata || err !== e.err || cyc != e.cyc) begin
            nMismatch++;
            $display("FAIL lat%0d resp: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     LAT, rdata, err, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      nCompared++;
      if (act !== want) begin
        nMismatch++;
        $display("FAIL lat%0d %s: got %h want %h", LAT, nm, act, want);
      end
    endtask

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b01) return a[0];
      if (sz[1])       return a[1:0] != 2'b00;
      return 1'b0;
    endfunction

    // Present one request at a negedge, wait for acceptance, log the expected
    // response and keep the model in step. Returns at the next negedge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] expR, input logic expE);
      exp_t e;
      int   n;
      req = 1'b1; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
      n = 0;
      while (!addr_ok && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!addr_ok) begin
        nCompared++;
        nMismatch++;
        $display("FAIL lat%0d accept timeout: addr_ok=%b want 1", LAT, addr_ok);
        req = 1'b0;
        return;
      end
      e.rdata = expR;
      e.err   = expE;
      e.cyc   = cyc + LAT;
      q.push_back(e);
      if (w && !misal(sz, a)) begin
        for (int i = 0; i < 4; i++)
          if (st[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
      end
      @(negedge clk);
      req = 1'b0;
    endtask

    initial begin
      logic        w;
      logic [1:0]  sz;
      logic [3:0]  st;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] er;
      logic        bad;
      int          n;

      rst = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00;
      wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;

      // Power-on reset state.
      repeat (2) @(negedge clk);
      chk("por data_ok", 32'(data_ok), 32'h0);
      chk("por rdata", rdata, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("por addr_ok", 32'(addr_ok), 32'h1);

      // Word store then load.
      issue(1'b1, 2'b10, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

      // Byte then half stores into the same word.
      issue(1'b1, 2'b00, 4'b1000, 32'h13, 32'h55000000, 32'h0, 1'b0);
      issue(1'b1, 2'b01, 4'b0011, 32'h10, 32'h00001234, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 4'h0, 32'h10, 32'h0, 32'h55AD1234, 1'b0);

      // Back-to-back byte store then load of the same word.
      issue(1'b1, 2'b10, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
      issue(1'b1, 2'b00, 4'b0001, 32'h20, 32'h000000AA, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 4'h0, 32'h20, 32'h0, 32'h112233AA, 1'b0);

      // Misaligned word load and half store; RAM must be untouched.
      issue(1'b0, 2'b10, 4'h0, 32'h22, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 2'b01, 4'b0110, 32'h21, 32'h00BEEF00, 32'h0, 1'b1);
      issue(1'b0, 2'b10, 4'h0, 32'h20, 32'h0, 32'h112233AA, 1'b0);

      // Address wrap past the RAM depth.
      issue(1'b1, 2'b10, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 4'h0, 32'h0000, 32'h0, 32'hCAFEF00D, 1'b0);

      // Reset right after a store is accepted discards it.
      issue(1'b1, 2'b10, 4'hF, 32'h30, 32'h01020304, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 4'h0, 32'h30, 32'h0, 32'h01020304, 1'b0);
      req = 1'b1; wr = 1'b1; size = 2'b10; wstrb = 4'hF;
      addr = 32'h30; wdata = 32'hFFFFFFFF;
      n = 0;
      while (!addr_ok && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("abort accept addr_ok", 32'(addr_ok), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 1'b0;
      repeat (3) @(negedge clk);
      chk("in-reset data_ok", 32'(data_ok), 32'h0);
      chk("in-reset rdata", rdata, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("post-reset addr_ok", 32'(addr_ok), 32'h1);
      chk("post-reset data_ok", 32'(data_ok), 32'h0);
      issue(1'b0, 2'b10, 4'h0, 32'h30, 32'h0, 32'h01020304, 1'b0);

      // Random sweep over 16 words, with aliased upper address bits.
      for (int i = 0; i < 16; i++)
        issue(1'b1, 2'b10, 4'hF, 32'h100 + 32'(i * 4), $urandom, 32'h0, 1'b0);
      for (int i = 0; i < 250; i++) begin
        w   = 1'($urandom_range(0, 1));
        sz  = 2'($urandom_range(0, 3));
        st  = 4'($urandom_range(0, 15));
        a   = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
        d   = $urandom;
        bad = misal(sz, a);
        er  = (w || bad) ? 32'h0 : model[a[11:2]];
        issue(w, sz, st, a, d, er, bad);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Drain outstanding responses.
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        nCompared++;
        nMismatch++;
        $display("FAIL lat%0d drain: %0d responses missing, want 0", LAT, q.size());
      end
      nDone++;
    end
  end

  initial begin
    int n;
    n = 0;
    while (nDone < 4 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (nDone < 4) begin
      nCompared++;
      nMismatch++;
      $display("FAIL run timeout: %0d lanes done, want 4", nDone);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
